// File: rtl/cache_ctrl_param_if.sv
// CPU and memory side signals of the direct-mapped cache controller.
// The cache uses the slave view; whoever drives the CPU requests and
// answers memory commands uses the master view.
interface cache_ctrl_param_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // CPU side
  logic              en;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              inv;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              hit;
  // Memory side
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_wack;

  modport slave (
    input  en, wr, addr, wdata, inv, mem_rdata, mem_rvalid, mem_wack,
    output rdata, stall, hit, mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output en, wr, addr, wdata, inv, mem_rdata, mem_rvalid, mem_wack,
    input  rdata, stall, hit, mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl_param.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Read hits complete combinationally in IDLE; read misses fill a whole
// line from memory one beat at a time; every write is forwarded to memory
// and the CPU is frozen until the memory acknowledges it.
module cache_ctrl_param #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LINES  = 8,
  parameter int WORDS  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_ctrl_param_if.slave  bus
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_LSB = OFF_W + IDX_W + 1;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

  state_t state_reg, state_next;

  // Address fields; bit 0 selects a byte within a word and is not used.
  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_lsb;

  assign offset          = bus.addr[OFF_W:1];
  assign index           = bus.addr[TAG_LSB-1:OFF_W+1];
  assign tag             = bus.addr[ADDR_W-1:TAG_LSB];
  assign unused_addr_lsb = bus.addr[0];

  // Line storage: valid bits are reset, tags and data are plain arrays.
  logic              valid_reg [LINES];
  logic [TAG_W-1:0]  tag_mem   [LINES];
  logic [DATA_W-1:0] data_mem  [LINES*WORDS];

  // Fill bookkeeping, captured when the miss is detected.
  logic [OFF_W-1:0]  beat_reg;
  logic [IDX_W-1:0]  fill_idx_reg;
  logic [TAG_W-1:0]  fill_tag_reg;

  // Registered memory command outputs.
  logic              mem_req_reg;
  logic              mem_wr_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic                    lookup_hit;
  logic                    miss_start;
  logic                    write_start;
  logic                    inv_accept;
  logic                    beat_we;
  logic                    fill_last;
  logic                    data_we;
  logic [IDX_W+OFF_W-1:0]  data_waddr;
  logic [DATA_W-1:0]       data_wdata;

  // Lookup and the decisions that follow from it in the current cycle.
  always_comb begin
    lookup_hit  = rst_n && (state_reg == IDLE) && bus.en &&
                  valid_reg[index] && (tag_mem[index] == tag);
    miss_start  = rst_n && (state_reg == IDLE) && bus.en && !bus.wr && !lookup_hit;
    write_start = rst_n && (state_reg == IDLE) && bus.en && bus.wr;
    // A miss or write takes priority; the requester keeps inv asserted.
    inv_accept  = rst_n && (state_reg == IDLE) && bus.inv && !miss_start && !write_start;
    beat_we     = rst_n && (state_reg == FILL) && bus.mem_rvalid;
    fill_last   = beat_we && (beat_reg == OFF_W'(WORDS - 1));
    // Fill beats and write hits never coincide, so one write port suffices.
    data_we     = beat_we || (write_start && lookup_hit);
    data_waddr  = beat_we ? {fill_idx_reg, beat_reg} : {index, offset};
    data_wdata  = beat_we ? bus.mem_rdata : bus.wdata;
  end

  assign bus.hit   = lookup_hit;
  assign bus.rdata = lookup_hit ? data_mem[{index, offset}] : '0;
  assign bus.stall = rst_n &&
                     ((state_reg == FILL) || (state_reg == WRITE) ||
                      ((state_reg == IDLE) && bus.en && (bus.wr || !lookup_hit)));

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_wr    = mem_wr_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  // Next-state selection for the access sequencer.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (write_start)     state_next = WRITE;
        else if (miss_start) state_next = FILL;
      end
      FILL:    if (fill_last)    state_next = IDLE;
      WRITE:   if (bus.mem_wack) state_next = WDONE;
      WDONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, beat counter and the one-cycle memory command pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      fill_idx_reg  <= '0;
      fill_tag_reg  <= '0;
      mem_req_reg   <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mem_req_reg <= 1'b0;
      if (miss_start) begin
        mem_req_reg  <= 1'b1;
        mem_wr_reg   <= 1'b0;
        mem_addr_reg <= {bus.addr[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
        fill_idx_reg <= index;
        fill_tag_reg <= tag;
        beat_reg     <= '0;
      end
      if (write_start) begin
        mem_req_reg   <= 1'b1;
        mem_wr_reg    <= 1'b1;
        mem_addr_reg  <= bus.addr;
        mem_wdata_reg <= bus.wdata;
      end
      if (beat_we) begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

  // One valid bit per line: cleared by reset or invalidate-all, set when
  // the last beat of that line's fill lands.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_reg[gi] <= 1'b0;
      end else if (inv_accept) begin
        valid_reg[gi] <= 1'b0;
      end else if (fill_last && (fill_idx_reg == IDX_W'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  // Tag is committed together with the valid bit at the end of a fill.
  always_ff @(posedge clk) begin
    if (fill_last) begin
      tag_mem[fill_idx_reg] <= fill_tag_reg;
    end
  end

  // Data words: fill beats and write-hit updates.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[data_waddr] <= data_wdata;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Bench for cache_ctrl_param: directed CPU accesses against a model of the
// cache contents kept as per-line arrays, a memory responder with a
// programmable delay, and one per-cycle compare process.
module tb_cache_ctrl_param;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LINES  = 8;
  localparam int WORDS  = 8;

  logic clk;
  logic rst_n;

  cache_ctrl_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_ctrl_param #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {PH_IDLE, PH_BUSY, PH_DONE, PH_RESET} phase_t;

  phase_t      phase;
  bit          checking;
  bit          exp_req;
  bit          exp_mem_wr;
  logic [15:0] exp_mem_addr;
  logic [15:0] exp_mem_wdata;
  int          vectors;
  int          miscompares;
  int          req_count;
  int          mem_delay;
  int          last_stall;
  logic [15:0] last_req_addr;

  bit          m_valid [LINES];
  int          m_tag   [LINES];
  logic [15:0] m_data  [LINES][WORDS];
  logic [15:0] backing [32768];

  bit          e_hit;
  bit          e_stall;
  logic [15:0] e_rdata;

  function automatic int line_of(input logic [15:0] a);
    return (int'(a) / 16) % LINES;
  endfunction

  function automatic int tag_of(input logic [15:0] a);
    return int'(a) / 128;
  endfunction

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) / 2) % WORDS;
  endfunction

  function automatic bit model_hit(input logic [15:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] a);
    return m_data[line_of(a)][word_of(a)];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare of the DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        if (phase == PH_RESET) begin
          chk("reset_stall", bus.stall, 0);
          chk("reset_hit", bus.hit, 0);
          chk("reset_rdata", bus.rdata, 0);
          chk("reset_mem_req", bus.mem_req, 0);
        end else begin
          e_hit   = (phase == PH_IDLE) && bus.en && model_hit(bus.addr);
          e_stall = (phase == PH_BUSY) ||
                    ((phase == PH_IDLE) && bus.en && (bus.wr || !e_hit));
          e_rdata = e_hit ? model_word(bus.addr) : 16'h0000;
          chk("hit", bus.hit, e_hit);
          chk("stall", bus.stall, e_stall);
          chk("rdata", bus.rdata, e_rdata);
          chk("mem_req", bus.mem_req, exp_req);
          if (exp_req) begin
            chk("mem_wr", bus.mem_wr, exp_mem_wr);
            chk("mem_addr", bus.mem_addr, exp_mem_addr);
            if (exp_mem_wr) chk("mem_wdata", bus.mem_wdata, exp_mem_wdata);
          end
        end
      end
      if (bus.mem_req) begin
        req_count++;
        last_req_addr = bus.mem_addr;
      end
    end
  end

  // Memory: answers each command mem_delay cycles after the request cycle.
  initial begin
    logic [15:0] ra;
    logic [15:0] rd;
    bit          rw;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_req) begin
        ra = bus.mem_addr;
        rw = bus.mem_wr;
        rd = bus.mem_wdata;
        repeat (mem_delay) @(posedge clk);
        #2;
        if (rw) begin
          if (rst_n) begin
            bus.mem_wack = 1'b1;
            backing[int'(ra) / 2] = rd;
            @(posedge clk);
            #2;
          end
          bus.mem_wack = 1'b0;
        end else begin
          for (int b = 0; b < WORDS; b++) begin
            if (!rst_n) break;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = backing[int'(ra) / 2 + b];
            @(posedge clk);
            #2;
          end
          bus.mem_rvalid = 1'b0;
        end
      end
    end
  end

  // One CPU access, scheduled from the documented latencies; returns the
  // data seen in the completion cycle and the number of stalled cycles.
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input int delay, input bit hold_inv, output logic [15:0] got);
    bit hit_now;
    int cnt;
    int ln;
    cnt       = 0;
    mem_delay = delay;
    hit_now   = model_hit(a);
    bus.en    = 1'b1;
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
    phase     = PH_IDLE;
    if (!w && hit_now) begin
      @(negedge clk);
      got = bus.rdata;
      cnt += int'(bus.stall);
      step();
    end else if (!w) begin
      bus.inv = hold_inv;
      @(negedge clk);
      cnt += int'(bus.stall);
      step();
      phase        = PH_BUSY;
      exp_req      = 1'b1;
      exp_mem_wr   = 1'b0;
      exp_mem_addr = 16'((int'(a) / 16) * 16);
      @(negedge clk);
      cnt += int'(bus.stall);
      step();
      exp_req = 1'b0;
      repeat (delay + WORDS - 1) begin
        @(negedge clk);
        cnt += int'(bus.stall);
        step();
      end
      ln = line_of(a);
      for (int i = 0; i < WORDS; i++) m_data[ln][i] = backing[(int'(a) / 16) * 8 + i];
      m_valid[ln] = 1'b1;
      m_tag[ln]   = tag_of(a);
      bus.inv     = 1'b0;
      phase       = PH_IDLE;
      @(negedge clk);
      got = bus.rdata;
      cnt += int'(bus.stall);
      step();
    end else begin
      @(negedge clk);
      cnt += int'(bus.stall);
      step();
      if (hit_now) m_data[line_of(a)][word_of(a)] = d;
      phase         = PH_BUSY;
      exp_req       = 1'b1;
      exp_mem_wr    = 1'b1;
      exp_mem_addr  = a;
      exp_mem_wdata = d;
      @(negedge clk);
      cnt += int'(bus.stall);
      step();
      exp_req = 1'b0;
      repeat (delay) begin
        @(negedge clk);
        cnt += int'(bus.stall);
        step();
      end
      phase = PH_DONE;
      @(negedge clk);
      got = bus.rdata;
      cnt += int'(bus.stall);
      step();
      phase = PH_IDLE;
    end
    bus.en     = 1'b0;
    bus.wr     = 1'b0;
    last_stall = cnt;
  endtask

  task automatic pulse_inv();
    bus.inv = 1'b1;
    @(negedge clk);
    step();
    bus.inv = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [15:0] got;
    int r0;
    vectors = 0; miscompares = 0; req_count = 0; mem_delay = 3; last_stall = 0;
    checking = 1'b0; exp_req = 1'b0; exp_mem_wr = 1'b0;
    exp_mem_addr = '0; exp_mem_wdata = '0; last_req_addr = '0;
    rst_n = 1'b0; phase = PH_RESET;
    bus.en = 1'b1; bus.wr = 1'b0; bus.addr = 16'h0046; bus.wdata = '0; bus.inv = 1'b0;
    bus.mem_rdata = '0; bus.mem_rvalid = 1'b0; bus.mem_wack = 1'b0;
    for (int i = 0; i < 32768; i++) backing[i] = 16'(32'hA000 + i - 32);
    clear_model();

    // Reset with a request pending: outputs must stay quiet.
    step();
    checking = 1'b1;
    repeat (2) begin @(negedge clk); step(); end
    rst_n = 1'b1; bus.en = 1'b0; phase = PH_IDLE;
    @(negedge clk);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    chk("rst_mem_wr", bus.mem_wr, 0);
    step();

    // Read miss with a 3-cycle memory delay.
    r0 = req_count;
    access(1'b0, 16'h0046, 16'h0000, 3, 1'b0, got);
    chk("s1_rdata", got, 16'hA003);
    chk("s1_stall_cycles", last_stall, 12);
    chk("s1_req_count", req_count - r0, 1);
    chk("s1_req_addr", last_req_addr, 16'h0040);

    // Back-to-back read hits.
    r0 = req_count;
    access(1'b0, 16'h0040, 16'h0000, 3, 1'b0, got);
    chk("s2_rdata0", got, 16'hA000);
    access(1'b0, 16'h004E, 16'h0000, 3, 1'b0, got);
    chk("s2_rdata1", got, 16'hA007);
    chk("s2_no_req", req_count - r0, 0);

    // Write hit, write miss on the same index, then read both back.
    r0 = req_count;
    access(1'b1, 16'h0042, 16'h1234, 2, 1'b0, got);
    chk("s3_wr_stall", last_stall, 4);
    chk("s3_req_addr0", last_req_addr, 16'h0042);
    access(1'b1, 16'h0842, 16'h5678, 1, 1'b0, got);
    chk("s3_req_addr1", last_req_addr, 16'h0842);
    chk("s3_req_count", req_count - r0, 2);
    r0 = req_count;
    access(1'b0, 16'h0042, 16'h0000, 3, 1'b0, got);
    chk("s3_read_hit", got, 16'h1234);
    chk("s3_hit_no_req", req_count - r0, 0);
    access(1'b0, 16'h0842, 16'h0000, 2, 1'b0, got);
    chk("s3_miss_fill", got, 16'h5678);
    chk("s3_miss_req", req_count - r0, 1);
    chk("s3_miss_addr", last_req_addr, 16'h0840);

    // Invalidate-all, then refill.
    pulse_inv();
    r0 = req_count;
    access(1'b0, 16'h0040, 16'h0000, 2, 1'b0, got);
    chk("s4_rdata", got, 16'hA000);
    chk("s4_req_count", req_count - r0, 1);
    chk("s4_req_addr", last_req_addr, 16'h0040);
    chk("s4_stall_cycles", last_stall, 11);

    // Spurious memory strobes while idle must change nothing.
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hDEAD; bus.mem_wack = 1'b1;
    repeat (2) begin @(negedge clk); step(); end
    bus.mem_rvalid = 1'b0; bus.mem_wack = 1'b0;
    r0 = req_count;
    access(1'b0, 16'h0042, 16'h0000, 2, 1'b0, got);
    chk("s6_hit_after_spurious", got, 16'h1234);
    chk("s6_spurious_no_req", req_count - r0, 0);

    // inv held during a miss is not accepted until the miss is done.
    access(1'b0, 16'h0266, 16'h0000, 2, 1'b1, got);
    chk("s6_inv_miss_rdata", got, 16'hA113);
    chk("s6_inv_miss_req", req_count - r0, 1);
    access(1'b0, 16'h0044, 16'h0000, 2, 1'b0, got);
    chk("s6_other_line_kept", got, 16'hA002);
    pulse_inv();
    r0 = req_count;
    access(1'b0, 16'h0266, 16'h0000, 1, 1'b0, got);
    chk("s6_after_inv_req", req_count - r0, 1);
    chk("s6_after_inv_rdata", got, 16'hA113);

    // Reset after beat 4 of a fill leaves the line invalid.
    mem_delay = 2; r0 = req_count;
    bus.en = 1'b1; bus.wr = 1'b0; bus.addr = 16'h0310; phase = PH_IDLE;
    @(negedge clk); step();
    phase = PH_BUSY; exp_req = 1'b1; exp_mem_wr = 1'b0; exp_mem_addr = 16'h0310;
    @(negedge clk); step();
    exp_req = 1'b0;
    repeat (mem_delay + 4) begin @(negedge clk); step(); end
    rst_n = 1'b0; phase = PH_RESET;
    repeat (2) begin @(negedge clk); step(); end
    rst_n = 1'b1; bus.en = 1'b0; phase = PH_IDLE;
    clear_model();
    chk("s5_partial_req", req_count - r0, 1);
    r0 = req_count;
    access(1'b0, 16'h0310, 16'h0000, 2, 1'b0, got);
    chk("s5_refill_req", req_count - r0, 1);
    chk("s5_refill_rdata", got, 16'hA168);
    access(1'b0, 16'h0266, 16'h0000, 1, 1'b0, got);
    chk("s5_old_line_gone", req_count - r0, 2);
    chk("s5_old_line_rdata", got, 16'hA113);

    repeat (2) begin @(negedge clk); step(); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_param.md
CACHE_CTRL_PARAM -- requirements
Module: cache_ctrl_param

Interface
REQ-001 Parameter ADDR_W, default 16, byte address width.
REQ-002 Parameter DATA_W, default 16, word width; one word is 2 bytes, so addr[0] is ignored.
REQ-003 Parameter LINES, default 8, line count; a power of 2, at least 2.
REQ-004 Parameter WORDS, default 8, words per line; a power of 2, at least 2.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 en  in  1  CPU access request, held stable by the CPU while stall=1.
REQ-008 wr  in  1  1=write, 0=read; qualified by en.
REQ-009 addr  in  ADDR_W  byte address.
REQ-010 wdata  in  DATA_W  store data.
REQ-011 inv  in  1  invalidate-all request.
REQ-012 rdata  out  DATA_W  load data.
REQ-013 stall  out  1  CPU freeze request.
REQ-014 hit  out  1  valid lookup hit.
REQ-015 mem_req  out  1  one-cycle memory command pulse.
REQ-016 mem_wr  out  1  1=write command; qualified by mem_req.
REQ-017 mem_addr  out  ADDR_W  command address.
REQ-018 mem_wdata  out  DATA_W  write data.
REQ-019 mem_rdata  in  DATA_W  fill beat data.
REQ-020 mem_rvalid  in  1  fill beat strobe.
REQ-021 mem_wack  in  1  write completion strobe.

Function
REQ-022 Address split SHALL be: offset=addr[log2(WORDS):1], index=next log2(LINES) bits, tag=remaining upper bits.
REQ-023 Each line SHALL hold a valid bit, a tag, and WORDS data words.
REQ-024 The FSM SHALL have exactly four states: IDLE, FILL, WRITE and WDONE.
REQ-025 hit SHALL be combinational: en & state==IDLE & valid[index] & tag match; hit=0 in all other states.
REQ-026 rdata SHALL be combinational, the addressed word when hit=1, else 0.
REQ-027 stall SHALL be combinational: (state is FILL or WRITE) | (state==IDLE & en & (wr | ~hit)).
REQ-028 A read hit in IDLE SHALL complete in the same cycle with zero added latency.
REQ-029 A read miss in IDLE SHALL move to FILL.
  - Next cycle: mem_req=1, mem_wr=0, mem_addr = addr with offset bits and bit 0 cleared.
  - mem_req SHALL stay high for that one cycle only.
REQ-030 In FILL, each mem_rvalid beat SHALL write mem_rdata into word[beat count] of the indexed line; the beat counter is log2(WORDS) bits and starts at 0.
REQ-031 On beat WORDS-1, the FSM SHALL set valid, write the tag and return to IDLE; the held read then hits on the following cycle.
  - Read-miss latency = 1 + memory delay + WORDS + 1 cycles.
REQ-032 Writes SHALL be write-through, no-write-allocate.
  - Write hit in IDLE: update the cached word on that edge.
  - Write miss: leave cache contents unchanged.
REQ-033 Any write in IDLE SHALL move to WRITE.
  - Next cycle: mem_req=1, mem_wr=1, mem_addr=addr, mem_wdata=wdata, for one cycle.
REQ-034 In WRITE, mem_wack SHALL move the FSM to WDONE.
REQ-035 In WDONE, stall=0 and the held write SHALL be consumed without a second memory command; the FSM then returns to IDLE.
REQ-036 mem_rvalid outside FILL and mem_wack outside WRITE SHALL be ignored.
REQ-037 inv SHALL clear all valid bits in one cycle when state==IDLE and no access is starting that cycle.
  - Otherwise inv is ignored; the requester holds it until accepted.
REQ-038 If inv and a miss or write coincide in IDLE, the access SHALL take priority and inv is not accepted.

Reset
REQ-039 rst_n=0 at a clock edge SHALL set state=IDLE, clear all valid bits and the beat counter, and drive mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-040 Reset during FILL SHALL leave the partially filled line invalid.
REQ-041 While rst_n=0, stall=0, hit=0 and rdata=0 SHALL hold; data arrays need no reset.

Verification
REQ-042 Use LINES=8, WORDS=8, so offset=addr[3:1], index=addr[6:4], tag=addr[15:7]. Scenario 1: after reset, read 0x0046 with memory returning beats 0xA000..0xA007 after a 3-cycle delay. Required: stall high, one mem_req with mem_addr=0x0040, then hit=1 and rdata=0xA003.
REQ-043 Scenario 2: back-to-back reads 0x0040 then 0x004E after scenario 1. Required: both hit with stall=0, rdata=0xA000 then 0xA007.
REQ-044 Scenario 3: write 0x1234 to 0x0042 (hit), then a write to 0x0842 (miss, same index). Required: each write issues one mem_wr pulse, stall holds until mem_wack, then one WDONE cycle. A later read of 0x0042 returns 0x1234 with hit=1, and 0x0842 still misses.
REQ-045 Scenario 4: pulse inv in IDLE, then read 0x0040. Required: miss, with a refill from mem_addr=0x0040.
REQ-046 Scenario 5: assert rst_n=0 after beat 4 of a fill, then read the same line. Required: miss and a full refill, with no stale hit.
REQ-047 Scenario 6: drive spurious mem_rvalid/mem_wack pulses in IDLE, and inv concurrent with a miss. Required: no state or array change from the pulses, and inv not accepted until the miss completes.
